jstk_txn_scheduler: RTL and testbench

Transaction scheduler for the PmodJSTK2 SPI interface. It replaces the free-running 20 Hz send/receive divider with a timed, handshaked sequencer. Each poll period it issues exactly one 5-byte transaction to the PmodJSTK SPI engine. It arbitrates between a pending RGB-LED update and a plain position read, then captures and decodes the returned 40-bit frame into X/Y/button outputs with a one-cycle valid strobe.

---
 rtl/jstk_txn_scheduler_pkg.sv | 26 ++
 rtl/jstk_frame_decode.sv | 20 ++
 rtl/jstk_txn_scheduler.sv | 155 +++++++++++++++
 tb/tb_jstk_txn_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/jstk_txn_scheduler_pkg.sv
// Shared PmodJSTK2 constants: command bytes, scheduler state encoding and
// bit positions of the X/Y/button fields inside the 40-bit returned frame.
package jstk_txn_scheduler_pkg;

  localparam logic [7:0] JSTK_CMD_LEDRGB = 8'h84;
  localparam logic [7:0] JSTK_CMD_GETPOS = 8'hC0;

  localparam int unsigned FRAME_W = 40;
  localparam int unsigned POS_W   = 10;
  localparam int unsigned BTN_W   = 2;

  // Low byte / high two bits of each position, and the button pair
  localparam int unsigned X_LO_LSB = 16;
  localparam int unsigned X_HI_LSB = 8;
  localparam int unsigned Y_LO_LSB = 32;
  localparam int unsigned Y_HI_LSB = 24;
  localparam int unsigned BTN_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_BUSY    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/jstk_frame_decode.sv
// Combinational decode of a PmodJSTK2 40-bit DOUT frame into X/Y/buttons.
module jstk_frame_decode
  import jstk_txn_scheduler_pkg::*;
(
  input  logic [FRAME_W-1:0] frame,
  output logic [POS_W-1:0]   xpos_c,
  output logic [POS_W-1:0]   ypos_c,
  output logic [BTN_W-1:0]   buttons_c
);

  logic unused_bits;

  assign xpos_c    = {frame[X_HI_LSB +: 2], frame[X_LO_LSB +: 8]};
  assign ypos_c    = {frame[Y_HI_LSB +: 2], frame[Y_LO_LSB +: 8]};
  assign buttons_c = frame[BTN_LSB +: BTN_W];

  // Padding bits of the frame carry no information
  assign unused_bits = ^{frame[31:26], frame[15:10], frame[7:2]};

endmodule

// File: rtl/jstk_txn_scheduler.sv
// Poll-rate sequencer for the PmodJSTK2 SPI engine: one 5-byte transaction per
// poll period, RGB update or position read, with watchdog and decoded capture.
module jstk_txn_scheduler
  import jstk_txn_scheduler_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned POLL_HZ     = 20,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rgb_req,
  input  logic [23:0] rgb_color,
  output logic        rgb_ack,
  output logic        snd_rec,
  output logic [39:0] din,
  input  logic        ss,
  input  logic [39:0] dout,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos,
  output logic [1:0]  buttons,
  output logic        sample_valid,
  output logic        timeout_err
);

  localparam int unsigned POLL_DIV = CLK_HZ / POLL_HZ;
  localparam int unsigned PW       = $clog2(POLL_DIV);
  localparam int unsigned WW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [39:0] DIN_RST  = {JSTK_CMD_GETPOS, 32'h0};

  state_e          state_q, state_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [WW-1:0]   wdog_q, wdog_d, wdog_inc;
  logic [39:0]     din_q, din_d;
  logic            cmd_rgb_q, cmd_rgb_d;
  logic            snd_rec_q, snd_rec_d;
  logic [9:0]      xpos_q, xpos_d, ypos_q, ypos_d;
  logic [1:0]      buttons_q, buttons_d;
  logic            sample_valid_q, sample_valid_d;
  logic            rgb_ack_q, rgb_ack_d;
  logic            timeout_err_q, timeout_err_d;
  logic            tick, wdog_hit;
  logic [9:0]      dec_x_c, dec_y_c;
  logic [1:0]      dec_btn_c;

  jstk_frame_decode u_decode (
    .frame     (dout),
    .xpos_c    (dec_x_c),
    .ypos_c    (dec_y_c),
    .buttons_c (dec_btn_c)
  );

  assign tick     = (poll_cnt_q == PW'(POLL_DIV - 1));
  assign wdog_inc = wdog_q + WW'(1);
  assign wdog_hit = (wdog_inc == WW'(TIMEOUT_CYC));

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    poll_cnt_d     = tick ? '0 : poll_cnt_q + PW'(1);
    wdog_d         = wdog_q;
    din_d          = din_q;
    cmd_rgb_d      = cmd_rgb_q;
    snd_rec_d      = 1'b0;
    xpos_d         = xpos_q;
    ypos_d         = ypos_q;
    buttons_d      = buttons_q;
    sample_valid_d = 1'b0;
    rgb_ack_d      = 1'b0;
    timeout_err_d  = timeout_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d   = ST_REQ;
          snd_rec_d = 1'b1;
          wdog_d    = '0;
          cmd_rgb_d = rgb_req;
          din_d     = rgb_req ? {JSTK_CMD_LEDRGB, rgb_color, 8'h00}
                              : {JSTK_CMD_GETPOS, 32'h0};
        end
      end
      ST_REQ: begin
        if (!ss) begin
          state_d = ST_BUSY;
          wdog_d  = '0;
        end else if (wdog_hit) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          snd_rec_d = 1'b1;
          wdog_d    = wdog_inc;
        end
      end
      ST_BUSY: begin
        // A completing transfer wins over a watchdog expiring the same cycle
        if (ss) begin
          state_d        = ST_CAPTURE;
          xpos_d         = dec_x_c;
          ypos_d         = dec_y_c;
          buttons_d      = dec_btn_c;
          sample_valid_d = 1'b1;
          rgb_ack_d      = cmd_rgb_q;
        end else if (wdog_hit) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      poll_cnt_q     <= '0;
      wdog_q         <= '0;
      din_q          <= DIN_RST;
      cmd_rgb_q      <= 1'b0;
      snd_rec_q      <= 1'b0;
      xpos_q         <= '0;
      ypos_q         <= '0;
      buttons_q      <= '0;
      sample_valid_q <= 1'b0;
      rgb_ack_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      poll_cnt_q     <= poll_cnt_d;
      wdog_q         <= wdog_d;
      din_q          <= din_d;
      cmd_rgb_q      <= cmd_rgb_d;
      snd_rec_q      <= snd_rec_d;
      xpos_q         <= xpos_d;
      ypos_q         <= ypos_d;
      buttons_q      <= buttons_d;
      sample_valid_q <= sample_valid_d;
      rgb_ack_q      <= rgb_ack_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign snd_rec      = snd_rec_q;
  assign din          = din_q;
  assign xpos         = xpos_q;
  assign ypos         = ypos_q;
  assign buttons      = buttons_q;
  assign sample_valid = sample_valid_q;
  assign rgb_ack      = rgb_ack_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_jstk_txn_scheduler.sv
// Directed bench for jstk_txn_scheduler at POLL_DIV=16, TIMEOUT_CYC=8; the
// bench plays the PmodJSTK engine by driving ss/dout cycle by cycle.
module tb_jstk_txn_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        rgb_req;
  logic [23:0] rgb_color;
  logic        rgb_ack;
  logic        snd_rec;
  logic [39:0] din;
  logic        ss;
  logic [39:0] dout;
  logic [9:0]  xpos;
  logic [9:0]  ypos;
  logic [1:0]  buttons;
  logic        sample_valid;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int n_cyc;
  int n_sv;

  jstk_txn_scheduler #(
    .CLK_HZ      (320),
    .POLL_HZ     (20),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rgb_req      (rgb_req),
    .rgb_color    (rgb_color),
    .rgb_ack      (rgb_ack),
    .snd_rec      (snd_rec),
    .din          (din),
    .ss           (ss),
    .dout         (dout),
    .xpos         (xpos),
    .ypos         (ypos),
    .buttons      (buttons),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until snd_rec rises (bounded); reports cycles taken and valid pulses seen
  task automatic wait_rise(input int max, output int n, output int sv);
    n  = 0;
    sv = 0;
    while (snd_rec !== 1'b1 && n < max) begin
      step(1);
      n++;
      if (sample_valid === 1'b1) sv++;
    end
  endtask

  initial begin
    rst = 1'b0; ss = 1'b1; dout = 40'h0; rgb_req = 1'b0; rgb_color = 24'h0;
    step(3);
    chk("rst_snd_rec", 40'(snd_rec), 40'h0);
    chk("rst_din", din, 40'hC000000000);
    chk("rst_xpos", 40'(xpos), 40'h0);
    chk("rst_ypos", 40'(ypos), 40'h0);
    chk("rst_buttons", 40'(buttons), 40'h0);
    chk("rst_sample_valid", 40'(sample_valid), 40'h0);
    chk("rst_rgb_ack", 40'(rgb_ack), 40'h0);
    chk("rst_timeout_err", 40'(timeout_err), 40'h0);
    rst = 1'b1;

    // Idle poll: first REQ exactly one poll period after reset release
    step(15);
    chk("poll_pre_tick", 40'(snd_rec), 40'h0);
    step(1);
    chk("poll_snd_rec_rise", 40'(snd_rec), 40'h1);
    chk("poll_din", din, 40'hC000000000);
    ss = 1'b0;
    step(1);
    chk("poll_snd_rec_drop", 40'(snd_rec), 40'h0);
    dout = 40'h1235560203;
    step(3);
    chk("poll_busy_no_valid", 40'(sample_valid), 40'h0);
    ss = 1'b1;
    step(1);
    chk("poll_valid", 40'(sample_valid), 40'h1);
    chk("poll_xpos", 40'(xpos), 40'h256);
    chk("poll_ypos", 40'(ypos), 40'h112);
    chk("poll_buttons", 40'(buttons), 40'h3);
    chk("poll_rgb_ack", 40'(rgb_ack), 40'h0);
    step(1);
    chk("poll_valid_pulse", 40'(sample_valid), 40'h0);

    // RGB update, then a position read entered with ss already low
    rgb_req = 1'b1; rgb_color = 24'hFF0080;
    wait_rise(40, n_cyc, n_sv);
    chk("rgb_wait", 40'(n_cyc), 40'd10);
    chk("rgb_din", din, 40'h84FF008000);
    ss = 1'b0;
    step(1);
    chk("rgb_snd_rec_drop", 40'(snd_rec), 40'h0);
    step(1);
    ss = 1'b1;
    step(1);
    chk("rgb_valid", 40'(sample_valid), 40'h1);
    chk("rgb_ack", 40'(rgb_ack), 40'h1);
    rgb_req = 1'b0;
    step(1);
    chk("rgb_ack_pulse", 40'(rgb_ack), 40'h0);
    ss = 1'b0;
    dout = 40'hAB02CD0301;
    wait_rise(40, n_cyc, n_sv);
    chk("pos_wait", 40'(n_cyc), 40'd12);
    chk("pos_din", din, 40'hC000000000);
    step(1);
    chk("pos_snd_rec_1cyc", 40'(snd_rec), 40'h0);
    ss = 1'b1;
    step(1);
    chk("pos_valid", 40'(sample_valid), 40'h1);
    chk("pos_xpos", 40'(xpos), 40'h3CD);
    chk("pos_ypos", 40'(ypos), 40'h2AB);
    chk("pos_buttons", 40'(buttons), 40'h1);
    chk("pos_rgb_ack", 40'(rgb_ack), 40'h0);
    step(1);

    // Long transfer ending in CAPTURE just as the next tick lands: tick dropped
    wait_rise(40, n_cyc, n_sv);
    chk("ovr_wait", 40'(n_cyc), 40'd13);
    step(6);
    chk("ovr_req_held", 40'(snd_rec), 40'h1);
    ss = 1'b0;
    step(1);
    chk("ovr_busy", 40'(snd_rec), 40'h0);
    step(7);
    chk("ovr_busy_no_valid", 40'(sample_valid), 40'h0);
    ss = 1'b1;
    step(1);
    chk("ovr_valid", 40'(sample_valid), 40'h1);
    chk("ovr_no_timeout", 40'(timeout_err), 40'h0);
    step(1);
    chk("ovr_tick_dropped", 40'(snd_rec), 40'h0);
    wait_rise(40, n_cyc, n_sv);
    chk("ovr_next_rise", 40'(n_cyc), 40'd16);

    // Timeout in REQ: engine never answers
    step(7);
    chk("to_req_held", 40'(snd_rec), 40'h1);
    step(1);
    chk("to_snd_rec_drop", 40'(snd_rec), 40'h0);
    chk("to_err_set", 40'(timeout_err), 40'h1);
    chk("to_no_valid", 40'(sample_valid), 40'h0);
    step(2);
    chk("to_err_sticky", 40'(timeout_err), 40'h1);
    dout = 40'h0101020202;
    wait_rise(40, n_cyc, n_sv);
    chk("to_recover_wait", 40'(n_cyc), 40'd6);
    chk("to_recover_no_valid", 40'(n_sv), 40'd0);
    ss = 1'b0;
    step(1);
    ss = 1'b1;
    step(1);
    chk("to_recover_valid", 40'(sample_valid), 40'h1);
    chk("to_recover_xpos", 40'(xpos), 40'h202);
    chk("to_recover_ypos", 40'(ypos), 40'h101);
    chk("to_err_still", 40'(timeout_err), 40'h1);
    step(1);

    // Reset while BUSY on an RGB command
    rgb_req = 1'b1; rgb_color = 24'h123456;
    wait_rise(40, n_cyc, n_sv);
    chk("mid_wait", 40'(n_cyc), 40'd13);
    chk("mid_din", din, 40'h8412345600);
    ss = 1'b0;
    step(2);
    rst = 1'b0;
    #1;
    chk("mid_rst_snd_rec", 40'(snd_rec), 40'h0);
    chk("mid_rst_din", din, 40'hC000000000);
    chk("mid_rst_xpos", 40'(xpos), 40'h0);
    chk("mid_rst_ypos", 40'(ypos), 40'h0);
    chk("mid_rst_timeout_err", 40'(timeout_err), 40'h0);
    step(2);
    ss = 1'b1;
    rst = 1'b1;
    wait_rise(40, n_cyc, n_sv);
    chk("post_rst_wait", 40'(n_cyc), 40'd16);
    chk("post_rst_no_valid", 40'(n_sv), 40'd0);
    chk("post_rst_din", din, 40'h8412345600);
    ss = 1'b0;
    step(1);
    ss = 1'b1;
    step(1);
    chk("post_rst_valid", 40'(sample_valid), 40'h1);
    chk("post_rst_rgb_ack", 40'(rgb_ack), 40'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
